// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : cpu_pkg                                                    |
// | Purpose  : Constants and encodings shared by the single-cycle CPU     |
// |            blocks (register file, decode, ALU).                       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package cpu_pkg;

   // Datapath and register-file geometry
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Architectural zero register index
   localparam logic [4:0] REG_ZERO = 5'd0;

   // ALU operation select, shared between decode and ALU
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_LUI = 3'b100
   } alu_op_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : reg_file                                                   |
// | Purpose  : 32 x 32 general-purpose register file for the single-cycle |
// |            CPU. Two combinational read ports feed the ALU operands;   |
// |            write-back commits on the rising clock edge. Register 0    |
// |            reads as zero and ignores writes.                          |
// | Options  : REG_FILE_DEBUG_PORT_EN adds a third combinational read     |
// |            port (DbgReg / DbgData) for board display or peeking.      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
   // Must equal 2**ADDR_W so every index selects a real register
   parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWre,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
`ifdef REG_FILE_DEBUG_PORT_EN
   ,
   input  logic [ADDR_W-1:0] DbgReg,
   output logic [DATA_W-1:0] DbgData
`endif
);

   // Current contents of every register; entry 0 is a constant zero
   logic [DATA_W-1:0] w_regs [NUM_REGS];

   // Shared read rule: index 0 always yields zero, others the stored word.
   // No bypass from WriteData: a write-through path would close a
   // combinational loop through the ALU in the single-cycle datapath.
   function automatic logic [DATA_W-1:0] reg_read(input logic [ADDR_W-1:0] idx);
      if (idx == ADDR_W'(REG_ZERO)) begin
         return '0;
      end
      return w_regs[idx];
   endfunction

   genvar i;
   generate
      for (i = 0; i < NUM_REGS; i++) begin : g_regs
         if (i == 0) begin : g_zero
            // No storage behind register 0; writes to it simply vanish
            assign w_regs[i] = '0;
         end else begin : g_entry
            logic              r_q;
            logic [DATA_W-1:0] r_data;
            logic              w_we;

            // RegWre gates the decode first, so an undriven WriteReg or
            // WriteData while RegWre is low can never reach the flops
            assign w_we = RegWre && (WriteReg == ADDR_W'(i));

            // Register storage: asynchronous clear dominates any write
            always_ff @(posedge CLK or negedge Reset) begin
               if (!Reset) begin
                  r_data <= '0;
               end else if (w_we) begin
                  r_data <= WriteData;
               end
            end

            assign w_regs[i] = r_data;
            assign r_q       = 1'b0;
         end
      end
   endgenerate

   // Read port 1 (rs): combinational, same-cycle valid
   always_comb begin
      ReadData1 = reg_read(ReadReg1);
   end

   // Read port 2 (rt): combinational, same-cycle valid
   always_comb begin
      ReadData2 = reg_read(ReadReg2);
   end

`ifdef REG_FILE_DEBUG_PORT_EN
   // Debug read port: observation only, no effect on architectural ports
   always_comb begin
      DbgData = reg_read(DbgReg);
   end
`endif

endmodule : reg_file
`default_nettype wire
